// File: rtl/vx_perf_gpu_collect_if.sv
// GPU-level performance stall counter bundle: producer drives the master side,
// the CSR/DCR read path consumes the slave side.
`ifndef PERF_CTR_BITS
`define PERF_CTR_BITS 44
`endif

interface vx_perf_gpu_if #(
  parameter int unsigned PERF_CTR_BITS = `PERF_CTR_BITS
) ();
  logic [PERF_CTR_BITS-1:0] wctl_stalls;
  logic [PERF_CTR_BITS-1:0] tex_stalls;
  logic [PERF_CTR_BITS-1:0] raster_stalls;
  logic [PERF_CTR_BITS-1:0] rop_stalls;
  logic [PERF_CTR_BITS-1:0] imadd_stalls;

  modport master (
    output wctl_stalls, tex_stalls, raster_stalls, rop_stalls, imadd_stalls
  );

  modport slave (
    input wctl_stalls, tex_stalls, raster_stalls, rop_stalls, imadd_stalls
  );
endinterface

// File: rtl/vx_perf_gpu_collect.sv
// Stall counters for the shared GPU units: two-stage sample/accumulate pipeline
// per unit slot plus an atomic snapshot bank for the CSR/DCR read path.
`ifndef PERF_CTR_BITS
`define PERF_CTR_BITS 44
`endif

module vx_perf_gpu_collect #(
  parameter int unsigned           NUM_UNITS     = 5,
  parameter int unsigned           NUM_REQS      = 4,
  parameter logic [NUM_UNITS-1:0]  UNIT_MASK     = {NUM_UNITS{1'b1}},
  parameter int unsigned           PERF_CTR_BITS = `PERF_CTR_BITS
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               perf_enable,
  input  logic                               perf_clear,
  input  logic [NUM_UNITS*NUM_REQS-1:0]      unit_req_valid,
  input  logic [NUM_UNITS*NUM_REQS-1:0]      unit_req_ready,
  input  logic                               snap_req,
  output logic                               snap_valid,
  output logic [NUM_UNITS*PERF_CTR_BITS-1:0] snap_counters,
  vx_perf_gpu_if.master                      perf_gpu_if
);

  localparam int unsigned INC_W = $clog2(NUM_REQS + 1);

  logic [INC_W-1:0]         inc_c [NUM_UNITS];
  logic [INC_W-1:0]         inc_r [NUM_UNITS];
  logic [PERF_CTR_BITS-1:0] ctr   [NUM_UNITS];
  logic [PERF_CTR_BITS-1:0] snap  [NUM_UNITS];

  // Popcount of stalled lanes (valid without ready) per unit.
  always_comb begin
    for (int u = 0; u < int'(NUM_UNITS); u++) begin
      inc_c[u] = '0;
      for (int r = 0; r < int'(NUM_REQS); r++) begin
        inc_c[u] = inc_c[u] + INC_W'(unit_req_valid[u*NUM_REQS+r] & ~unit_req_ready[u*NUM_REQS+r]);
      end
    end
  end

  // Stage 1: gated sample. Masked slots are tied to constant zero.
  always_ff @(posedge clk) begin
    for (int u = 0; u < int'(NUM_UNITS); u++) begin
      if (reset || perf_clear || !perf_enable || !UNIT_MASK[u]) begin
        inc_r[u] <= '0;
      end else begin
        inc_r[u] <= inc_c[u];
      end
    end
  end

  // Stage 2: wrapping accumulate; clear wins over the in-flight increment.
  always_ff @(posedge clk) begin
    for (int u = 0; u < int'(NUM_UNITS); u++) begin
      if (reset || perf_clear || !UNIT_MASK[u]) begin
        ctr[u] <= '0;
      end else begin
        ctr[u] <= ctr[u] + PERF_CTR_BITS'(inc_r[u]);
      end
    end
  end

  // Snapshot captures the counters as seen in the request cycle (pre-clear).
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_valid <= 1'b0;
      for (int u = 0; u < int'(NUM_UNITS); u++) snap[u] <= '0;
    end else begin
      snap_valid <= snap_req;
      if (snap_req) begin
        for (int u = 0; u < int'(NUM_UNITS); u++) snap[u] <= ctr[u];
      end
    end
  end

  for (genvar u = 0; u < int'(NUM_UNITS); u++) begin : g_snap
    assign snap_counters[u*PERF_CTR_BITS +: PERF_CTR_BITS] = snap[u];
  end

  assign perf_gpu_if.wctl_stalls   = ctr[0];
  assign perf_gpu_if.tex_stalls    = ctr[1];
  assign perf_gpu_if.raster_stalls = ctr[2];
  assign perf_gpu_if.rop_stalls    = ctr[3];
  assign perf_gpu_if.imadd_stalls  = ctr[4];

endmodule

// File: tb/tb_vx_perf_gpu_collect.sv
// Scoreboard bench for vx_perf_gpu_collect: directed scenarios plus random traffic
// against a prefix-sum model of the counters.
module tb_vx_perf_gpu_collect;

  localparam int unsigned NU   = 5;
  localparam int unsigned NR   = 4;
  localparam int unsigned W    = 8;
  localparam logic [NU-1:0] MASK = 5'b11011;
  localparam int          MAXC = 4000;

  typedef struct packed {
    int              cyc;
    logic [NU*W-1:0] vals;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset;
  logic               perf_enable;
  logic               perf_clear;
  logic [NU*NR-1:0]   unit_req_valid;
  logic [NU*NR-1:0]   unit_req_ready;
  logic               snap_req;
  logic               snap_valid;
  logic [NU*W-1:0]    snap_counters;

  vx_perf_gpu_if #(.PERF_CTR_BITS(W)) pgi ();

  vx_perf_gpu_collect #(
    .NUM_UNITS(NU), .NUM_REQS(NR), .UNIT_MASK(MASK), .PERF_CTR_BITS(W)
  ) dut (
    .clk(clk), .reset(reset), .perf_enable(perf_enable), .perf_clear(perf_clear),
    .unit_req_valid(unit_req_valid), .unit_req_ready(unit_req_ready),
    .snap_req(snap_req), .snap_valid(snap_valid), .snap_counters(snap_counters),
    .perf_gpu_if(pgi)
  );

  always #5 clk = ~clk;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   last_clr = -1;
  int   pre [MAXC][NU];
  exp_t live_q [$];
  exp_t snap_q [$];

  // Expected counters during cycle t: gated stall counts of cycles after the
  // last clear/reset and at least two edges old, modulo 2^W.
  function automatic logic [NU*W-1:0] model_at(int t, int lc);
    logic [NU*W-1:0] v = '0;
    if (lc >= 0 && t - 2 > lc) begin
      for (int u = 0; u < int'(NU); u++) v[u*W +: W] = W'(pre[t-2][u] - pre[lc][u]);
    end
    return v;
  endfunction

  task automatic step(input logic [NU*NR-1:0] v, input logic [NU*NR-1:0] r,
                      input logic en, input logic clr, input logic snap, input logic rst);
    exp_t e;
    int   t;
    @(posedge clk);
    #1;
    unit_req_valid = v;
    unit_req_ready = r;
    perf_enable    = en;
    perf_clear     = clr;
    snap_req       = snap;
    reset          = rst;
    t = cyc;
    cyc++;
    for (int u = 0; u < int'(NU); u++) begin
      int inc = 0;
      if (en && !clr && !rst && MASK[u]) inc = $countones(v[u*NR +: NR] & ~r[u*NR +: NR]);
      pre[t][u] = (t == 0) ? inc : pre[t-1][u] + inc;
    end
    e.cyc  = t;
    e.vals = model_at(t, last_clr);
    live_q.push_back(e);
    if (snap && !rst) begin
      e.cyc = t + 1;
      snap_q.push_back(e);
    end
    if (clr || rst) last_clr = t;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compares live counters every cycle and the snapshot bank on snap_valid.
  initial begin
    exp_t e, s;
    logic [NU*W-1:0] live;
    forever begin
      @(negedge clk);
      if (live_q.size() > 0) begin
        e = live_q.pop_front();
        if (e.cyc > 0) begin
          live = {pgi.imadd_stalls, pgi.rop_stalls, pgi.raster_stalls, pgi.tex_stalls, pgi.wctl_stalls};
          for (int u = 0; u < int'(NU); u++) begin
            vectors++;
            if (live[u*W +: W] !== e.vals[u*W +: W]) begin
              miscompares++;
              $display("FAIL live_ctr cyc=%0d slot=%0d got=%0d exp=%0d", e.cyc, u, live[u*W +: W], e.vals[u*W +: W]);
            end
          end
          vectors++;
          if (snap_q.size() > 0 && snap_q[0].cyc == e.cyc) begin
            s = snap_q.pop_front();
            if (snap_valid !== 1'b1) begin
              miscompares++;
              $display("FAIL snap_valid cyc=%0d got=%b exp=1", e.cyc, snap_valid);
            end else begin
              for (int u = 0; u < int'(NU); u++) begin
                vectors++;
                if (snap_counters[u*W +: W] !== s.vals[u*W +: W]) begin
                  miscompares++;
                  $display("FAIL snap_slot cyc=%0d slot=%0d got=%0d exp=%0d", e.cyc, u, snap_counters[u*W +: W], s.vals[u*W +: W]);
                end
              end
            end
          end else if (snap_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL snap_valid cyc=%0d got=%b exp=0", e.cyc, snap_valid);
          end
        end
      end
    end
  end

  initial begin
    logic [NU*NR-1:0] all1 = '1;
    logic [NU*NR-1:0] rdy;
    reset = 1'b1; perf_enable = 1'b0; perf_clear = 1'b0; snap_req = 1'b0;
    unit_req_valid = '0; unit_req_ready = '0;

    step('0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    step('0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    // No stalls when every lane is ready.
    for (int i = 0; i < 10; i++) step(all1, all1, 1'b1, 1'b0, 1'b0, 1'b0);
    // Tex lanes 0 and 2 stalled for five cycles.
    rdy = all1; rdy[NR+0] = 1'b0; rdy[NR+2] = 1'b0;
    for (int i = 0; i < 5; i++) step(all1, rdy, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    // All wctl lanes stalled, enable alternating, then clear right after.
    rdy = all1; rdy[NR-1:0] = '0;
    for (int i = 0; i < 6; i++) step(all1, rdy, i[0], 1'b0, 1'b0, 1'b0);
    step('0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(3);
    // Drive rop to 255, then two more stalls wrap it to 1.
    rdy = all1; rdy[3*NR +: NR] = '0;
    for (int i = 0; i < 63; i++) step(all1, rdy, 1'b1, 1'b0, 1'b0, 1'b0);
    rdy[3*NR +: NR] = 4'b1000;
    step(all1, rdy, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    rdy[3*NR +: NR] = 4'b1100;
    step(all1, rdy, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(3);
    // wctl=7, tex=3, then snapshot together with clear, then a second snapshot.
    step('0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    rdy = all1; rdy[3:0] = 4'b0000; rdy[NR +: NR] = 4'b1000;
    step(all1, rdy, 1'b1, 1'b0, 1'b0, 1'b0);
    rdy = all1; rdy[3:0] = 4'b1000;
    step(all1, rdy, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    step('0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(3);
    step('0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
    step('0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(2);
    // Random traffic with occasional clear, snapshot and reset.
    for (int i = 0; i < 1500; i++) begin
      step(20'($urandom), 20'($urandom), ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 99) == 0));
    end
    // Reset lands on stalls and a snapshot request in flight.
    step(all1, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(all1, '0, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(4);

    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (snap_q.size() != 0 || live_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain snap_pending=%0d live_pending=%0d exp=0", snap_q.size(), live_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
